// File: rtl/imem_port_arbiter_if.sv
// Loader, fetch and instruction-memory signal bundle for imem_port_arbiter.
// master: requester/memory side, slave: arbiter side.
interface imem_port_arbiter_if #(
    parameter int unsigned WIDTH1 = 32
);
    logic              load_req;
    logic [WIDTH1-1:0] load_addr;
    logic [WIDTH1-1:0] load_wdata;
    logic              load_gnt;

    logic              fetch_req;
    logic [WIDTH1-1:0] fetch_addr;
    logic              fetch_flush;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [WIDTH1-1:0] fetch_rdata;

    logic [WIDTH1-1:0] mem_addr;
    logic              mem_wr;
    logic [WIDTH1-1:0] mem_wdata;
    logic [WIDTH1-1:0] mem_rdata;

    logic              oob_err;

    modport master (
        output load_req, load_addr, load_wdata,
        output fetch_req, fetch_addr, fetch_flush,
        output mem_rdata,
        input  load_gnt, fetch_gnt, fetch_rvalid, fetch_rdata,
        input  mem_addr, mem_wr, mem_wdata, oob_err
    );

    modport slave (
        input  load_req, load_addr, load_wdata,
        input  fetch_req, fetch_addr, fetch_flush,
        input  mem_rdata,
        output load_gnt, fetch_gnt, fetch_rvalid, fetch_rdata,
        output mem_addr, mem_wr, mem_wdata, oob_err
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port, 1-cycle-latency instruction memory between the program
// loader (writes) and the fetch unit (reads), with bounded loader bursts.
module imem_port_arbiter #(
    parameter int unsigned WIDTH1       = 32,
    parameter int unsigned MEM_SIZE     = 1024,
    parameter int unsigned MAX_WR_BURST = 4
) (
    input logic                clk,
    input logic                reset,
    imem_port_arbiter_if.slave bus
);
    localparam int unsigned       STREAK_W   = $clog2(MAX_WR_BURST + 1);
    localparam logic [WIDTH1-1:0] ADDR_LIMIT = WIDTH1'(MEM_SIZE);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_BURST);

    logic [STREAK_W-1:0] wr_streak_q;
    logic                rd_pend_q;
    logic                oob_q;
    logic                oob_err_q;

    logic fetch_ok_c;
    logic fetch_turn_c;
    logic load_gnt_c;
    logic fetch_gnt_c;
    logic load_oob_c;
    logic fetch_oob_c;
    logic rvalid_c;

    // Arbitration: loader first, fetch forced through after a full write burst.
    always_comb begin
        fetch_ok_c   = bus.fetch_req & ~bus.fetch_flush;
        fetch_turn_c = fetch_ok_c & (wr_streak_q == STREAK_MAX);
        load_gnt_c   = ~reset & bus.load_req & ~fetch_turn_c;
        fetch_gnt_c  = ~reset & fetch_ok_c & ~load_gnt_c;
        load_oob_c   = (bus.load_addr >= ADDR_LIMIT);
        fetch_oob_c  = (bus.fetch_addr >= ADDR_LIMIT);
        rvalid_c     = ~reset & rd_pend_q & ~bus.fetch_flush;
    end

    // Memory drive and response outputs; out-of-range writes are dropped here.
    always_comb begin
        bus.load_gnt     = load_gnt_c;
        bus.fetch_gnt    = fetch_gnt_c;
        bus.mem_wr       = load_gnt_c & ~load_oob_c;
        bus.mem_addr     = load_gnt_c ? bus.load_addr : bus.fetch_addr;
        bus.mem_wdata    = load_gnt_c ? bus.load_wdata : '0;
        bus.fetch_rvalid = rvalid_c;
        bus.fetch_rdata  = (rvalid_c && !oob_q) ? bus.mem_rdata : '0;
        bus.oob_err      = oob_err_q;
    end

    // Consecutive load grants; saturates so a late fetch request still wins next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_streak_q <= '0;
        end else if (fetch_gnt_c || !bus.load_req) begin
            wr_streak_q <= '0;
        end else if (load_gnt_c && (wr_streak_q != STREAK_MAX)) begin
            wr_streak_q <= wr_streak_q + STREAK_W'(1);
        end
    end

    // Read pipeline: one pending slot that refills on back-to-back grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            rd_pend_q <= fetch_gnt_c;
            if (fetch_gnt_c) begin
                oob_q <= fetch_oob_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_err_q <= 1'b0;
        end else if ((load_gnt_c && load_oob_c) || (fetch_gnt_c && fetch_oob_c)) begin
            oob_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: memory model, shadow of written
// words and a queue of expected read data.
module tb_imem_port_arbiter;
    localparam int unsigned W  = 32;
    localparam int unsigned MS = 1024;
    localparam int unsigned MB = 4;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic reset;

    imem_port_arbiter_if #(.WIDTH1(W)) bus ();

    imem_port_arbiter #(
        .WIDTH1      (W),
        .MEM_SIZE    (MS),
        .MAX_WR_BURST(MB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem    [0:MS-1];
    logic [W-1:0] shadow [0:MS-1];
    logic [W-1:0] exp_q  [$];
    int checks = 0;
    int errors = 0;

    // Synchronous-read memory that holds rdata during writes.
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;
        else            bus.mem_rdata <= mem[bus.mem_addr[AW-1:0]];
    end

    task automatic idle_inputs();
        bus.load_req    = 1'b0;
        bus.load_addr   = '0;
        bus.load_wdata  = '0;
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_flush = 1'b0;
    endtask

    task automatic do_load(input int a, input logic [W-1:0] d);
        @(negedge clk);
        idle_inputs();
        bus.load_req   = 1'b1;
        bus.load_addr  = W'(a);
        bus.load_wdata = d;
        if (a < int'(MS)) shadow[a] = d;
        @(posedge clk);
        #1 bus.load_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2 bus.load_req = 1'b1;
        bus.fetch_req = 1'b1;
        #1;
        checks++;
        if (bus.load_gnt !== 1'b0 || bus.fetch_gnt !== 1'b0 || bus.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL in_reset_grants: load_gnt=%b fetch_gnt=%b mem_wr=%b, required 0 0 0",
                     bus.load_gnt, bus.fetch_gnt, bus.mem_wr);
        end
        checks++;
        if (bus.fetch_rvalid !== 1'b0 || bus.fetch_rdata !== '0) begin
            errors++;
            $display("FAIL in_reset_read: rvalid=%b rdata=%h, required 0 0",
                     bus.fetch_rvalid, bus.fetch_rdata);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.load_gnt !== 1'b0 || bus.fetch_gnt !== 1'b0 || bus.mem_wr !== 1'b0 ||
            bus.fetch_rvalid !== 1'b0 || bus.oob_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: lg=%b fg=%b wr=%b rv=%b oob=%b, required all 0",
                     bus.load_gnt, bus.fetch_gnt, bus.mem_wr, bus.fetch_rvalid, bus.oob_err);
        end
    endtask

    task automatic test_load_fetch();
        logic [W-1:0] e;
        @(negedge clk);
        idle_inputs();
        bus.load_req   = 1'b1;
        bus.load_addr  = W'(5);
        bus.load_wdata = 32'h00A0_0093;
        shadow[5]      = 32'h00A0_0093;
        #1;
        checks++;
        if (bus.load_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0 || bus.mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL load_grant: lg=%b fg=%b wr=%b, required 1 0 1",
                     bus.load_gnt, bus.fetch_gnt, bus.mem_wr);
        end
        checks++;
        if (bus.mem_addr !== W'(5) || bus.mem_wdata !== 32'h00A0_0093) begin
            errors++;
            $display("FAIL load_drive: addr=%h wdata=%h, required 5 00a00093",
                     bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(5);
        #1;
        checks++;
        if (bus.fetch_gnt !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== W'(5)) begin
            errors++;
            $display("FAIL fetch_grant: fg=%b wr=%b addr=%h, required 1 0 5",
                     bus.fetch_gnt, bus.mem_wr, bus.mem_addr);
        end
        exp_q.push_back(32'h00A0_0093);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== e) begin
            errors++;
            $display("FAIL fetch_data: rv=%b rdata=%h, required 1 %h",
                     bus.fetch_rvalid, bus.fetch_rdata, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.fetch_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: rv=%b, required 0", bus.fetch_rvalid);
        end
        do_load(3, 32'h1111_2222);
    endtask

    task automatic test_arbitration();
        int streak = 0;
        int nl = 0;
        int nf = 0;
        int la = 200;
        logic prev_f = 1'b0;
        logic exp_f;
        logic [W-1:0] e;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        bus.load_req   = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(5);
        for (int i = 0; i < 12; i++) begin
            bus.load_addr  = W'(la);
            bus.load_wdata = 32'h5000_0000 + W'(la);
            #1;
            exp_f = (streak == int'(MB));
            checks++;
            if (bus.load_gnt !== !exp_f || bus.fetch_gnt !== exp_f) begin
                errors++;
                $display("FAIL arb_grant[%0d]: lg=%b fg=%b, required %b %b",
                         i, bus.load_gnt, bus.fetch_gnt, !exp_f, exp_f);
            end
            if (prev_f) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== e) begin
                    errors++;
                    $display("FAIL arb_read[%0d]: rv=%b rdata=%h, required 1 %h",
                             i, bus.fetch_rvalid, bus.fetch_rdata, e);
                end
            end
            nl += int'(bus.load_gnt);
            nf += int'(bus.fetch_gnt);
            if (exp_f) begin
                exp_q.push_back(shadow[5]);
                streak = 0;
            end else begin
                shadow[la] = 32'h5000_0000 + W'(la);
                la++;
                streak++;
            end
            prev_f = exp_f;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++;
        if (nl != 10 || nf != 2) begin
            errors++;
            $display("FAIL arb_counts: loads=%0d fetches=%0d, required 10 2", nl, nf);
        end
    endtask

    task automatic test_back_to_back();
        int addrs[4] = '{5, 3, 200, 201};
        logic [W-1:0] e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i < 4) begin
                bus.fetch_req  = 1'b1;
                bus.fetch_addr = W'(addrs[i]);
            end
            #1;
            if (i < 4) begin
                checks++;
                if (bus.fetch_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_grant[%0d]: fg=%b, required 1", i, bus.fetch_gnt);
                end
            end
            if (i > 0) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== e) begin
                    errors++;
                    $display("FAIL b2b_read[%0d]: rv=%b rdata=%h, required 1 %h",
                             i, bus.fetch_rvalid, bus.fetch_rdata, e);
                end
            end
            if (i < 4) exp_q.push_back(shadow[addrs[i]]);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] e;
        @(negedge clk);
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(3);
        #1;
        checks++;
        if (bus.fetch_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_grant: fg=%b, required 1", bus.fetch_gnt);
        end
        @(negedge clk);
        bus.fetch_req   = 1'b0;
        bus.fetch_flush = 1'b1;
        #1;
        checks++;
        if (bus.fetch_rvalid !== 1'b0 || bus.fetch_rdata !== '0) begin
            errors++;
            $display("FAIL flush_rvalid: rv=%b rdata=%h, required 0 0",
                     bus.fetch_rvalid, bus.fetch_rdata);
        end
        @(negedge clk);
        bus.fetch_req = 1'b1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 1'b0) begin
            errors++;
            $display("FAIL flush_grant: fg=%b, required 0", bus.fetch_gnt);
        end
        @(negedge clk);
        bus.load_req   = 1'b1;
        bus.load_addr  = W'(7);
        bus.load_wdata = 32'h7777_0007;
        shadow[7]      = 32'h7777_0007;
        #1;
        checks++;
        if (bus.load_gnt !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== W'(7)) begin
            errors++;
            $display("FAIL flush_load: lg=%b wr=%b addr=%h, required 1 1 7",
                     bus.load_gnt, bus.mem_wr, bus.mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.fetch_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_read: rv=%b, required 0", bus.fetch_rvalid);
        end
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(7);
        exp_q.push_back(shadow[7]);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== e) begin
            errors++;
            $display("FAIL flush_write_kept: rv=%b rdata=%h, required 1 %h",
                     bus.fetch_rvalid, bus.fetch_rdata, e);
        end
    endtask

    task automatic test_oob();
        logic [W-1:0] e;
        do_load(976, 32'hCAFE_F00D);
        @(negedge clk);
        idle_inputs();
        bus.load_req   = 1'b1;
        bus.load_addr  = W'(1024);
        bus.load_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.load_gnt !== 1'b1 || bus.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL oob_load: lg=%b wr=%b, required 1 0", bus.load_gnt, bus.mem_wr);
        end
        @(negedge clk);
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(2000);
        #1;
        checks++;
        if (bus.oob_err !== 1'b1 || bus.fetch_gnt !== 1'b1) begin
            errors++;
            $display("FAIL oob_flag: oob=%b fg=%b, required 1 1", bus.oob_err, bus.fetch_gnt);
        end
        exp_q.push_back('0);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== e) begin
            errors++;
            $display("FAIL oob_read: rv=%b rdata=%h, required 1 %h",
                     bus.fetch_rvalid, bus.fetch_rdata, e);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [W-1:0] e;
        @(negedge clk);
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(5);
        #1;
        checks++;
        if (bus.fetch_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_grant: fg=%b, required 1", bus.fetch_gnt);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 1'b0 || bus.oob_err !== 1'b0 || bus.fetch_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: fg=%b oob=%b rv=%b, required 0 0 0",
                     bus.fetch_gnt, bus.oob_err, bus.fetch_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.fetch_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: rv=%b, required 0", bus.fetch_rvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.fetch_rvalid !== 1'b0 || bus.load_gnt !== 1'b0 || bus.fetch_gnt !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: rv=%b lg=%b fg=%b, required 0 0 0",
                     bus.fetch_rvalid, bus.load_gnt, bus.fetch_gnt);
        end
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = W'(4096);
        exp_q.push_back('0);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (bus.oob_err !== 1'b1 || bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== e) begin
            errors++;
            $display("FAIL fetch_oob: oob=%b rv=%b rdata=%h, required 1 1 %h",
                     bus.oob_err, bus.fetch_rvalid, bus.fetch_rdata, e);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < int'(MS); i++) shadow[i] = '0;
        test_reset();
        test_load_fetch();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_oob();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters: the program loader (writes) and the fetch unit (reads).
- Sits between the loader/fetch logic and the instruction memory, and drives its addr, wr and wdata inputs.
- Tracks the 1-cycle read latency, returns read data with a valid strobe, and enforces loader/fetch fairness.
- Drops out-of-range accesses and flags them.

Parameters:
- WIDTH1, 32: data and address width.
- MEM_SIZE, 1024: number of memory words; valid word index is 0..MEM_SIZE-1.
- MAX_WR_BURST, 4: maximum consecutive loader grants while fetch is waiting.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  loader requests a write; held until granted.
- load_addr  input  WIDTH1  word index to write.
- load_wdata  input  WIDTH1  write data.
- load_gnt  output  1  write accepted this cycle (combinational).
- fetch_req  input  1  fetch requests a read; held until granted.
- fetch_addr  input  WIDTH1  word index to read.
- fetch_flush  input  1  redirect: kill pending/new read.
- fetch_gnt  output  1  read accepted this cycle (combinational).
- fetch_rvalid  output  1  read data valid.
- fetch_rdata  output  WIDTH1  read data.
- mem_addr  output  WIDTH1  to memory addr.
- mem_wr  output  1  to memory wr.
- mem_wdata  output  WIDTH1  to memory wdata.
- mem_rdata  input  WIDTH1  from memory rdata (registered in memory).
- oob_err  output  1  sticky out-of-range access flag.

Behaviour:
- Handshake
  - A request is held until its grant is seen. The transfer occurs in the cycle where req and gnt are both high.
  - At most one grant per cycle.
- Arbitration
  - Loader has priority by default.
  - wr_streak counts consecutive load grants. It increments on each load grant and clears on any fetch grant or any cycle with load_req=0.
  - If fetch_req=1, fetch_flush=0 and wr_streak==MAX_WR_BURST, fetch wins; load_gnt=0 that cycle.
  - fetch_gnt is forced 0 while fetch_flush=1.
- Memory drive
  - On a load grant: mem_wr=1, mem_addr=load_addr, mem_wdata=load_wdata.
  - Otherwise: mem_wr=0, mem_addr=fetch_addr, mem_wdata=0.
  - A load grant with load_addr>=MEM_SIZE sets mem_wr=0 (write dropped) and sets oob_err.
- Read pipeline
  - A fetch grant in cycle T sets rd_pend_q=1 at the edge ending T. It also captures oob_q = (fetch_addr>=MEM_SIZE) and sets oob_err if out of range.
  - In T+1: fetch_rvalid = rd_pend_q & ~fetch_flush.
  - fetch_rdata = mem_rdata when rvalid and oob_q=0; fetch_rdata = 0 when oob_q=1 or rvalid=0.
  - rd_pend_q clears the next cycle unless a new fetch grant occurs, so back-to-back reads give rvalid every cycle.
  - A load grant in T+1 does not corrupt T+1 data: the memory holds rdata during writes.
- oob_err is sticky until reset.
- Reset
  - Asynchronous: rd_pend_q, oob_q, wr_streak and oob_err clear to 0 immediately.
  - While reset=1: load_gnt, fetch_gnt, mem_wr and fetch_rvalid are 0, and fetch_rdata is 0.
  - Reset mid-read discards the pending read; no rvalid after release.
- Simultaneous events
  - Both req high with streak<MAX_WR_BURST: loader wins.
  - fetch_flush in the grant cycle: no grant.
  - fetch_flush in the rvalid cycle: rvalid suppressed.
  - fetch_flush during a load grant: no effect on the write.

Test Plan:
- Reset release, no requests -> all grants 0, mem_wr=0, fetch_rvalid=0, oob_err=0.
- Load addr 5 data 0x00A00093, then fetch addr 5 -> fetch_gnt in cycle T; rvalid=1 with rdata=0x00A00093 in T+1.
- load_req and fetch_req held high together for 12 cycles, MAX_WR_BURST=4 -> grant pattern L,L,L,L,F repeating (10 L, 2 F in 12 cycles).
- Fetch addr 3 granted, fetch_flush=1 next cycle -> fetch_rvalid=0; fetch_flush=1 with fetch_req -> fetch_gnt=0.
- Load addr 1024 -> load_gnt=1, mem_wr=0, oob_err=1. Fetch addr 2000 -> rvalid=1, rdata=0.
- Fetch granted, then reset pulsed before the next edge -> rvalid stays 0 and grants drop immediately.
